multichannel_time_buffer: RTL and testbench
===========================================

# multichannel_time_buffer

Snapshot-and-replay sample buffer between the antenna A2D front end and the FFT. It captures a fixed-length snapshot of `CHANNELS` parallel sample streams, then replays it as `RUNS` overlapping batches per channel, with each run's window shifted by `STEP` samples. The output is an Avalon-ST-style source with backpressure. The block supersedes the dual-clock single-channel buffer: it runs in one clock domain and adds a channel count, a window step, sink qualification, backpressure and repeatable replay.

## Interface
- `DATA_WIDTH`, 14: bits per sample.
- `CHANNELS`, 2: parallel input channels; must be ≥1.
- `BATCH_SIZE`, 2048: samples per output batch; must be ≥2.
- `RUNS`, 3: overlapping batches per channel; must be ≥1.
- `STEP`, 1: window shift in samples between consecutive runs; must be ≥1.
- `clk`  in  1  single clock; all ports synchronous to it.
- `reset`  in  1  synchronous, active-high reset.
- `arm`  in  1  pulse: start a new capture.
- `sink_valid`  in  1  qualifies `sink_data`.
- `sink_data`  in  CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- `ready`  out  1  high: snapshot complete, replay may start.
- `start`  in  1  pulse: begin replay.
- `busy`  out  1  high during capture or replay.
- `done`  out  1  one-cycle pulse after the last beat is accepted.
- `source_ready`  in  1  downstream accepts beat.
- `source_valid`, `source_sop`, `source_eop`  out  1 each.
- `source_data`  out  DATA_WIDTH.
- `source_channel`  out  max(1,$clog2(CHANNELS)).
- `source_run`  out  max(1,$clog2(RUNS)).

## Operation
- TOT_SIZE = BATCH_SIZE + (RUNS-1)*STEP samples per channel. Address width is $clog2(TOT_SIZE).
- States: IDLE, CAPTURE, LOADED, REPLAY.
- IDLE --arm--> CAPTURE. Write pointer clears to 0.
- CAPTURE: each cycle with `sink_valid` high writes all channels at the write pointer, and the pointer increments. After the write at TOT_SIZE-1, the block goes to LOADED.
- LOADED --start--> REPLAY. LOADED --arm--> CAPTURE, which overwrites the snapshot.
- REPLAY: beat order is run-major, then channel, then sample. Run r, channel c, sample i outputs buf[c][r*STEP+i].
- `source_sop` is high when i==0. `source_eop` is high when i==BATCH_SIZE-1.
- After the last beat (r=RUNS-1, c=CHANNELS-1, i=BATCH_SIZE-1) is accepted: `done` pulses and the block returns to LOADED. The snapshot is retained, so `start` may replay it again.
- Ignored inputs: `start` outside LOADED; `arm` during REPLAY.
- `arm` during CAPTURE restarts the capture at pointer 0.
- If `arm` and `start` are asserted together in LOADED, `arm` wins.
- `ready` = (state==LOADED). `busy` = (state==CAPTURE or REPLAY).

## Timing
- Reset, and every output's value after it:
  - State goes to IDLE and the snapshot is invalid.
  - `ready`, `busy`, `done`, `source_valid`, `source_sop` and `source_eop` are 0.
  - `source_data`, `source_channel` and `source_run` are 0.
- Reset mid-capture or mid-replay aborts immediately. No `done` pulse is produced.
- Capture writes on the same edge at which `sink_valid` is sampled. `ready` rises the cycle after the final write.
- Replay latency: with `start` sampled at edge 0 and `source_ready` held high, `source_valid` first rises after edge 2. This accounts for the 1-cycle RAM read plus the output register.
- Throughput with `source_ready` high: 1 beat per cycle, with no bubbles between batches, channels or runs. Total beats = RUNS*CHANNELS*BATCH_SIZE.
- Handshake: a beat transfers when `source_valid && source_ready`. While `source_valid && !source_ready`, all `source_*` outputs hold stable.
- `source_valid` never drops mid-replay once raised, until the final beat transfers.
- `done` is high on the cycle after the final transfer. `ready` rises on that same cycle.

## Structure
- Package `time_buffer_pkg`:
  - state enum;
  - function `tot_size(BATCH_SIZE,RUNS,STEP)`;
  - width helper `clog2_min1`.
- Sub-module `sdp_ram`: one write port and one read port, parameters DEPTH and WIDTH, 1-cycle registered read. It is instantiated once with width CHANNELS*DATA_WIDTH, and the channel is selected after the read.
- The top level contains:
  - the FSM;
  - the write pointer;
  - the run/channel/sample counters;
  - a one-entry skid register, which absorbs the in-flight read when `source_ready` drops.

## Test plan
Configuration for all scenarios: DATA_WIDTH=8, CHANNELS=2, BATCH_SIZE=4, RUNS=3, STEP=2, giving TOT_SIZE=8. Capture data is a ramp: ch0=k, ch1=0x80+k.
- Arm, 8 valid samples, start, `source_ready` high:
  - 24 beats, ch0 0-3, ch1 80-83, ch0 2-5, ch1 82-85, ch0 4-7, ch1 84-87;
  - sop/eop on every 4th beat; `source_run` 0,1,2;
  - first valid 2 cycles after start; `done` one cycle after beat 24.
- `sink_valid` toggled 50% during capture: 8 samples stored in order; `ready` rises only after the 8th valid sample.
- `source_ready` random 30% low: identical 24-beat sequence with no drops or duplicates; outputs stable while stalled.
- A second `start` after `done`: the same 24 beats replay. `start` asserted during REPLAY, and `arm` asserted during REPLAY, have no effect.
- Reset asserted at beat 10: on the next cycle all outputs are 0, `ready`=0 and there is no `done` pulse. A following `start` is ignored until a new capture completes.
- `arm` asserted after 5 captured samples: capture restarts. The next 8 samples (value 0x40+k) are the only ones replayed.

Source files
------------

// File: rtl/time_buffer_pkg.sv
// Shared types and sizing helpers for the multichannel snapshot/replay buffer.
package time_buffer_pkg;

  // Top-level control states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_LOADED  = 2'd2,
    ST_REPLAY  = 2'd3
  } state_t;

  // Samples held per channel so every shifted run window fits in the snapshot.
  function automatic int tot_size(input int batch_size, input int runs, input int step);
    return batch_size + (runs - 1) * step;
  endfunction

  // $clog2 that never returns 0, so single-value fields still get one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
module sdp_ram
  import time_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/multichannel_time_buffer.sv
// Snapshot-and-replay buffer: captures CHANNELS parallel sample streams, then
// replays RUNS overlapping windows per channel through a backpressured source.
module multichannel_time_buffer
  import time_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int CHANNELS   = 2,
  parameter int BATCH_SIZE = 2048,
  parameter int RUNS       = 3,
  parameter int STEP       = 1,
  localparam int CW = clog2_min1(CHANNELS),
  localparam int RW = clog2_min1(RUNS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           arm,
  input  logic                           sink_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] sink_data,
  output logic                           ready,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  input  logic                           source_ready,
  output logic                           source_valid,
  output logic                           source_sop,
  output logic                           source_eop,
  output logic [DATA_WIDTH-1:0]          source_data,
  output logic [CW-1:0]                  source_channel,
  output logic [RW-1:0]                  source_run
);

  localparam int TOT = tot_size(BATCH_SIZE, RUNS, STEP);
  localparam int AW  = clog2_min1(TOT);
  localparam int IW  = clog2_min1(BATCH_SIZE);
  localparam int WW  = CHANNELS * DATA_WIDTH;

  localparam logic [AW-1:0] LAST_ADDR = AW'(TOT - 1);
  localparam logic [AW-1:0] STEP_ADDR = AW'(STEP);
  localparam logic [IW-1:0] LAST_SAMP = IW'(BATCH_SIZE - 1);
  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);
  localparam logic [RW-1:0] LAST_RUN  = RW'(RUNS - 1);

  // One output beat plus a marker for the final beat of the whole replay.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [CW-1:0]         chan;
    logic [RW-1:0]         run;
    logic                  sop;
    logic                  eop;
    logic                  last;
  } beat_t;

  state_t          state_reg;
  logic [AW-1:0]   wr_ptr_reg;

  // Read-issue counters; base_reg tracks run*STEP without a multiplier.
  logic [IW-1:0]   samp_reg;
  logic [CW-1:0]   chan_reg;
  logic [RW-1:0]   run_reg;
  logic [AW-1:0]   base_reg;
  logic            issuing_reg;

  // Sideband travelling alongside the RAM read.
  logic            rd_valid_reg;
  logic [CW-1:0]   rd_chan_reg;
  logic [RW-1:0]   rd_run_reg;
  logic            rd_sop_reg;
  logic            rd_eop_reg;
  logic            rd_last_reg;
  logic [WW-1:0]   rd_word;
  logic [DATA_WIDTH-1:0] lane [CHANNELS];

  beat_t           rd_beat;
  beat_t           out_reg, out_next;
  beat_t           skid_reg, skid_next;
  logic            out_valid_reg, out_valid_next;
  logic            skid_valid_reg, skid_valid_next;
  logic            done_reg;

  logic            wr_en;
  logic            issue;
  logic            pop;
  logic            out_free;
  logic            final_xfer;
  logic [AW-1:0]   rd_addr;

  // An arm in the same cycle as a sample restarts the capture and drops that sample.
  assign wr_en      = (state_reg == ST_CAPTURE) && sink_valid && !arm;
  assign rd_addr    = base_reg + AW'(samp_reg);
  assign pop        = out_valid_reg && source_ready;
  assign out_free   = pop || !out_valid_reg;
  assign final_xfer = (state_reg == ST_REPLAY) && pop && out_reg.last;
  // Only issue a read if its result is guaranteed a slot next cycle, i.e. the
  // skid register will be empty after this edge.
  assign issue      = (state_reg == ST_REPLAY) && issuing_reg && !skid_valid_next;

  sdp_ram #(
    .DEPTH(TOT),
    .WIDTH(WW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata (sink_data),
    .re    (issue),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // Split the RAM word into per-channel lanes; the channel is picked after the read.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    assign lane[gi] = rd_word[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Assemble the beat coming out of the RAM this cycle.
  always_comb begin
    rd_beat      = '0;
    rd_beat.data = lane[rd_chan_reg];
    rd_beat.chan = rd_chan_reg;
    rd_beat.run  = rd_run_reg;
    rd_beat.sop  = rd_sop_reg;
    rd_beat.eop  = rd_eop_reg;
    rd_beat.last = rd_last_reg;
  end

  // Output register refill: skid entry first, then the fresh RAM read; a read
  // that arrives while the output is stalled parks in the skid register.
  always_comb begin
    out_valid_next  = out_valid_reg;
    out_next        = out_reg;
    skid_valid_next = skid_valid_reg;
    skid_next       = skid_reg;
    if (out_free) begin
      if (skid_valid_reg) begin
        out_valid_next  = 1'b1;
        out_next        = skid_reg;
        skid_valid_next = rd_valid_reg;
        if (rd_valid_reg) skid_next = rd_beat;
      end else if (rd_valid_reg) begin
        out_valid_next = 1'b1;
        out_next       = rd_beat;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (rd_valid_reg) begin
      skid_valid_next = 1'b1;
      skid_next       = rd_beat;
    end
  end

  // Control FSM, capture write pointer and replay read-issue counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      wr_ptr_reg  <= '0;
      samp_reg    <= '0;
      chan_reg    <= '0;
      run_reg     <= '0;
      base_reg    <= '0;
      issuing_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arm) begin
            state_reg  <= ST_CAPTURE;
            wr_ptr_reg <= '0;
          end
        end
        ST_CAPTURE: begin
          if (arm) begin
            wr_ptr_reg <= '0;
          end else if (sink_valid) begin
            if (wr_ptr_reg == LAST_ADDR) state_reg <= ST_LOADED;
            else wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
        end
        ST_LOADED: begin
          if (arm) begin
            state_reg  <= ST_CAPTURE;
            wr_ptr_reg <= '0;
          end else if (start) begin
            state_reg   <= ST_REPLAY;
            samp_reg    <= '0;
            chan_reg    <= '0;
            run_reg     <= '0;
            base_reg    <= '0;
            issuing_reg <= 1'b1;
          end
        end
        ST_REPLAY: begin
          if (final_xfer) state_reg <= ST_LOADED;
          if (issue) begin
            if (samp_reg == LAST_SAMP) begin
              samp_reg <= '0;
              if (chan_reg == LAST_CHAN) begin
                chan_reg <= '0;
                if (run_reg == LAST_RUN) begin
                  issuing_reg <= 1'b0;
                end else begin
                  run_reg  <= run_reg + 1'b1;
                  base_reg <= base_reg + STEP_ADDR;
                end
              end else begin
                chan_reg <= chan_reg + 1'b1;
              end
            end else begin
              samp_reg <= samp_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Read pipeline sideband, output/skid registers and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_reg   <= 1'b0;
      rd_chan_reg    <= '0;
      rd_run_reg     <= '0;
      rd_sop_reg     <= 1'b0;
      rd_eop_reg     <= 1'b0;
      rd_last_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_reg        <= '0;
      skid_valid_reg <= 1'b0;
      skid_reg       <= '0;
      done_reg       <= 1'b0;
    end else begin
      rd_valid_reg   <= issue;
      if (issue) begin
        rd_chan_reg <= chan_reg;
        rd_run_reg  <= run_reg;
        rd_sop_reg  <= (samp_reg == '0);
        rd_eop_reg  <= (samp_reg == LAST_SAMP);
        rd_last_reg <= (samp_reg == LAST_SAMP) && (chan_reg == LAST_CHAN) &&
                       (run_reg == LAST_RUN);
      end
      out_valid_reg  <= out_valid_next;
      out_reg        <= out_next;
      skid_valid_reg <= skid_valid_next;
      skid_reg       <= skid_next;
      done_reg       <= final_xfer;
    end
  end

  assign ready          = (state_reg == ST_LOADED);
  assign busy           = (state_reg == ST_CAPTURE) || (state_reg == ST_REPLAY);
  assign done           = done_reg;
  assign source_valid   = out_valid_reg;
  assign source_sop     = out_reg.sop;
  assign source_eop     = out_reg.eop;
  assign source_data    = out_reg.data;
  assign source_channel = out_reg.chan;
  assign source_run     = out_reg.run;

endmodule

// File: tb/tb_multichannel_time_buffer.sv
// Self-checking bench for multichannel_time_buffer (DW=8, CH=2, BS=4, RUNS=3, STEP=2).
module tb_multichannel_time_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic        sink_valid = 1'b0;
  logic [15:0] sink_data = '0;
  logic        ready;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        source_ready = 1'b1;
  logic        source_valid;
  logic        source_sop;
  logic        source_eop;
  logic [7:0]  source_data;
  logic        source_channel;
  logic [1:0]  source_run;

  multichannel_time_buffer #(
    .DATA_WIDTH(8), .CHANNELS(2), .BATCH_SIZE(4), .RUNS(3), .STEP(2)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .sink_valid(sink_valid),
    .sink_data(sink_data), .ready(ready), .start(start), .busy(busy),
    .done(done), .source_ready(source_ready), .source_valid(source_valid),
    .source_sop(source_sop), .source_eop(source_eop), .source_data(source_data),
    .source_channel(source_channel), .source_run(source_run)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       ch;
    logic [1:0] run;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct {
    logic        arm;
    logic        start;
    logic        sink_valid;
    logic [15:0] sink_data;
    logic        exp_ready;
    logic        exp_busy;
  } vec_t;

  beat_t      exp_q[$];
  logic [7:0] model_mem [2][8];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int beats_seen = 0;
  int done_count = 0;
  int done_cyc = 0;
  int last_cyc = 0;
  logic done_ready = 1'b0;
  logic seen_valid = 1'b0;
  logic prev_stall = 1'b0;
  beat_t prev_beat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard fill: run-major, then channel, then sample.
  task automatic push_expected();
    beat_t b;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 4; i++) begin
          b.data = model_mem[c][r*2+i];
          b.ch   = c[0];
          b.run  = r[1:0];
          b.sop  = (i == 0);
          b.eop  = (i == 3);
          exp_q.push_back(b);
        end
  endtask

  // Output monitor: scoreboard pops, stall stability, valid continuity, done timing.
  always @(negedge clk) begin
    beat_t act;
    beat_t e;
    act = {source_data, source_channel, source_run, source_sop, source_eop};
    if (reset) begin
      seen_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!source_valid || act != prev_beat) begin
          failures++;
          $display("FAIL stall_hold: got v=%0d %h expected v=1 %h", source_valid, act, prev_beat);
        end
      end
      if (seen_valid && !done) begin
        checks++;
        if (!source_valid) begin
          failures++;
          $display("FAIL valid_drop: got valid=0 expected 1 at cycle %0d", cyc);
        end
      end
      if (source_valid) seen_valid = 1'b1;
      if (done) begin
        seen_valid = 1'b0;
        done_count++;
        done_cyc   = cyc;
        done_ready = ready;
      end
      if (source_valid && source_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got %h expected none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL beat%0d: got %h expected %h", beats_seen, act, e);
          end
        end
        beats_seen++;
        last_cyc = cyc;
      end
      prev_stall = source_valid && !source_ready;
      prev_beat  = act;
    end
  end

  // Full replay with optional random backpressure and ignored start/arm pulses.
  task automatic run_replay(input int low_pct, input bit inject, input bit check_lat);
    int dc0;
    int n;
    dc0 = done_count;
    push_expected();
    source_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (check_lat) begin
      check("lat_edge0_valid", source_valid, 0);
      check("lat_edge0_busy", busy, 1);
      tick();
      check("lat_edge1_valid", source_valid, 0);
      tick();
      check("lat_edge2_valid", source_valid, 1);
      check("lat_edge2_sop", source_sop, 1);
    end
    n = 0;
    while (done_count == dc0 && n < 400) begin
      source_ready = ($urandom_range(0, 99) >= low_pct);
      start = inject && (n == 6);
      arm   = inject && (n == 9);
      tick();
      n++;
    end
    start = 1'b0;
    arm = 1'b0;
    source_ready = 1'b1;
    check("replay_done_seen", done_count - dc0, 1);
    check("replay_beats_left", exp_q.size(), 0);
    check("done_after_last", done_cyc, last_cyc + 1);
    check("ready_at_done", done_ready, 1);
    check("done_is_pulse", done, 0);
    check("ready_after_replay", ready, 1);
    check("busy_after_replay", busy, 0);
  endtask

  initial begin
    vec_t vecs[17];
    int k;
    int n;
    int dc0;
    int b0;

    // Capture table: arm, then sink_valid on every other cycle, with a stray start.
    k = 0;
    for (int r = 0; r < 17; r++) begin
      vecs[r].arm        = (r == 0);
      vecs[r].start      = (r == 5);
      vecs[r].sink_valid = (r != 0) && (r % 2 == 0);
      vecs[r].sink_data  = '0;
      if (vecs[r].sink_valid) begin
        vecs[r].sink_data = {8'(128 + k), 8'(k)};
        model_mem[0][k] = 8'(k);
        model_mem[1][k] = 8'(128 + k);
        k++;
      end
      vecs[r].exp_ready = (r == 16);
      vecs[r].exp_busy  = (r != 16);
    end

    // Reset state.
    tick();
    tick();
    check("rst_valid", source_valid, 0);
    check("rst_sop", source_sop, 0);
    check("rst_eop", source_eop, 0);
    check("rst_data", source_data, 0);
    check("rst_channel", source_channel, 0);
    check("rst_run", source_run, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    tick();
    check("idle_ready", ready, 0);
    check("idle_busy", busy, 0);

    for (int r = 0; r < 17; r++) begin
      arm        = vecs[r].arm;
      start      = vecs[r].start;
      sink_valid = vecs[r].sink_valid;
      sink_data  = vecs[r].sink_data;
      tick();
      check($sformatf("cap_row%0d_ready", r), ready, vecs[r].exp_ready);
      check($sformatf("cap_row%0d_busy", r), busy, vecs[r].exp_busy);
    end
    arm = 1'b0;
    start = 1'b0;
    sink_valid = 1'b0;
    check("cap_valid_idle", source_valid, 0);

    // Replays: full throughput with latency, random backpressure, ignored pulses.
    run_replay(0, 1'b0, 1'b1);
    run_replay(30, 1'b0, 1'b0);
    run_replay(0, 1'b1, 1'b0);

    // Reset at beat 10 of a replay.
    dc0 = done_count;
    b0 = beats_seen;
    push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (beats_seen < b0 + 10 && n < 100) begin
      tick();
      n++;
    end
    check("reset_wait_beat10", beats_seen - b0, 10);
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("abort_valid", source_valid, 0);
    check("abort_sop", source_sop, 0);
    check("abort_eop", source_eop, 0);
    check("abort_data", source_data, 0);
    check("abort_channel", source_channel, 0);
    check("abort_run", source_run, 0);
    check("abort_ready", ready, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_abort_valid%0d", i), source_valid, 0);
      check($sformatf("post_abort_busy%0d", i), busy, 0);
      check($sformatf("post_abort_ready%0d", i), ready, 0);
    end
    check("abort_no_done", done_count - dc0, 0);

    // Capture restart: 5 throwaway samples, re-arm, then 8 kept samples.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sink_valid = 1'b1;
      sink_data  = {8'(160 + i), 8'(32 + i)};
      tick();
    end
    sink_valid = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("rearm_ready", ready, 0);
    check("rearm_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      sink_valid = 1'b1;
      sink_data  = {8'(192 + i), 8'(64 + i)};
      model_mem[0][i] = 8'(64 + i);
      model_mem[1][i] = 8'(192 + i);
      tick();
      check($sformatf("rearm_ready_s%0d", i), ready, (i == 7) ? 1 : 0);
    end
    sink_valid = 1'b0;
    run_replay(0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
